// File: rtl/reading_history_if.sv
// Signal bundle between the sensor/browse controls and the reading history buffer.
// The master drives samples and controls; the slave returns history, view and stats.
interface reading_history_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 10
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic             sample_valid;
   logic [WIDTH-1:0] sample;
   logic             browse_next;
   logic             hist_clear;
   logic             saved;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] view_idx;
   logic [WIDTH-1:0] view_data;
   logic             view_valid;
   logic [WIDTH-1:0] min_val;
   logic [WIDTH-1:0] max_val;
   logic [WIDTH-1:0] avg_val;
   logic             stats_busy;

   modport master (
      output sample_valid, sample, browse_next, hist_clear,
      input  saved, count, view_idx, view_data, view_valid,
             min_val, max_val, avg_val, stats_busy
   );

   modport slave (
      input  sample_valid, sample, browse_next, hist_clear,
      output saved, count, view_idx, view_data, view_valid,
             min_val, max_val, avg_val, stats_busy
   );
endinterface

// File: rtl/reading_history_buf.sv
// Stability-filtered reading history: commits steady readings into a circular buffer,
// serves a browse view and keeps min/max/average via a sequential scan-and-divide engine.
module reading_history_buf #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 10,
   parameter int STABLE_N = 4,
   parameter int TOL      = 1
) (
   input logic              clk,
   input logic              rst_n,
   reading_history_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = WIDTH + CNT_W;
   localparam int DC_W  = $clog2(SUM_W + 1);
   localparam int RUN_W = $clog2(STABLE_N + 1);

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED} trk_e;
   typedef enum logic [1:0] {SIDLE, SCAN, DIV} st_e;

   function automatic logic in_tol(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic signed [WIDTH:0] diff;
      diff = $signed({1'b0, a}) - $signed({1'b0, b});
      if (diff < 0) diff = -diff;
      return diff <= $signed((WIDTH+1)'(TOL));
   endfunction

   // Age k lives at (wr_ptr - 1 - k) mod DEPTH; add DEPTH first so nothing goes negative.
   function automatic logic [PTR_W-1:0] age_addr(input logic [PTR_W-1:0] wp,
                                                 input logic [CNT_W-1:0] age);
      logic [PTR_W+1:0] s;
      s = {2'b00, wp} + (PTR_W+2)'(DEPTH - 1) - (PTR_W+2)'(age);
      if (s >= (PTR_W+2)'(DEPTH)) s = s - (PTR_W+2)'(DEPTH);
      return s[PTR_W-1:0];
   endfunction

   trk_e             trk_q, trk_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] view_idx_q, view_idx_d;
   logic [WIDTH-1:0] view_data_q, view_data_d;
   logic             saved_q, saved_d;
   st_e              st_q, st_d;
   logic [CNT_W-1:0] scan_k_q, scan_k_d;
   logic [WIDTH-1:0] min_acc_q, min_acc_d, max_acc_q, max_acc_d;
   logic [SUM_W-1:0] sum_q, sum_d, dvd_q, dvd_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [DC_W-1:0]  div_cnt_q, div_cnt_d;
   logic [WIDTH-1:0] min_val_q, min_val_d, max_val_q, max_val_d, avg_val_q, avg_val_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             commit, wr_en, qbit;
   logic [WIDTH-1:0] entry;
   logic [CNT_W:0]   rem_sh;

   always_comb begin
      trk_d = trk_q; cand_d = cand_q; run_d = run_q; commit = 1'b0;
      if (bus.sample_valid) begin
         unique case (trk_q)
            IDLE: if (bus.sample != '0) begin
               cand_d = bus.sample; run_d = RUN_W'(1); trk_d = TRACK;
            end
            TRACK: if (bus.sample == '0) trk_d = IDLE;
               else if (in_tol(bus.sample, cand_q)) run_d = run_q + 1'b1;
               else begin cand_d = bus.sample; run_d = RUN_W'(1); end
            LOCKED: if (bus.sample == '0) trk_d = IDLE;
               else if (!in_tol(bus.sample, cand_q)) begin
                  cand_d = bus.sample; run_d = RUN_W'(1); trk_d = TRACK;
               end
            default: trk_d = IDLE;
         endcase
         if (trk_d == TRACK && run_d == RUN_W'(STABLE_N)) begin
            commit = 1'b1; trk_d = LOCKED;
         end
      end
      if (bus.hist_clear) begin
         trk_d = IDLE; cand_d = '0; run_d = '0;
      end
   end

   assign wr_en = commit && !bus.hist_clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q; count_d = count_q; view_idx_d = view_idx_q;
      saved_d  = wr_en;
      if (bus.hist_clear) begin
         wr_ptr_d = '0; count_d = '0; view_idx_d = '0;
      end else if (wr_en) begin
         wr_ptr_d   = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         count_d    = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + 1'b1;
         view_idx_d = '0;
      end else if (bus.browse_next && count_q != '0) begin
         view_idx_d = (CNT_W'(view_idx_q) + CNT_W'(1) == count_q) ? '0 : view_idx_q + 1'b1;
      end
      view_data_d = (count_q == '0) ? '0 : mem_q[age_addr(wr_ptr_q, CNT_W'(view_idx_q))];
   end

   // Stats engine: SCAN walks ages 0..count-1, DIV produces one quotient bit per cycle.
   always_comb begin
      st_d = st_q; scan_k_d = scan_k_q; min_acc_d = min_acc_q; max_acc_d = max_acc_q;
      sum_d = sum_q; dvd_d = dvd_q; rem_d = rem_q; div_cnt_d = div_cnt_q;
      min_val_d = min_val_q; max_val_d = max_val_q; avg_val_d = avg_val_q; busy_d = busy_q;
      entry  = mem_q[age_addr(wr_ptr_q, scan_k_q)];
      rem_sh = {rem_q, dvd_q[SUM_W-1]};
      qbit   = 1'b0;
      if (bus.hist_clear) begin
         st_d = SIDLE; busy_d = 1'b0;
         min_val_d = '0; max_val_d = '0; avg_val_d = '0;
      end else if (wr_en) begin
         st_d = SCAN; busy_d = 1'b1; scan_k_d = '0;
         min_acc_d = '1; max_acc_d = '0; sum_d = '0;
      end else begin
         unique case (st_q)
            SCAN: begin
               min_acc_d = (entry < min_acc_q) ? entry : min_acc_q;
               max_acc_d = (entry > max_acc_q) ? entry : max_acc_q;
               sum_d     = sum_q + SUM_W'(entry);
               scan_k_d  = scan_k_q + 1'b1;
               if (scan_k_q + 1'b1 == count_q) begin
                  st_d = DIV; dvd_d = sum_q + SUM_W'(entry); rem_d = '0; div_cnt_d = '0;
               end
            end
            DIV: begin
               if (rem_sh >= {1'b0, count_q}) begin
                  rem_d = CNT_W'(rem_sh - {1'b0, count_q}); qbit = 1'b1;
               end else begin
                  rem_d = CNT_W'(rem_sh);
               end
               dvd_d     = {dvd_q[SUM_W-2:0], qbit};
               div_cnt_d = div_cnt_q + 1'b1;
               if (div_cnt_q == DC_W'(SUM_W - 1)) begin
                  st_d = SIDLE; busy_d = 1'b0;
                  min_val_d = min_acc_q; max_val_d = max_acc_q; avg_val_d = dvd_d[WIDTH-1:0];
               end
            end
            default: st_d = SIDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk_q <= IDLE; cand_q <= '0; run_q <= '0;
         wr_ptr_q <= '0; count_q <= '0; view_idx_q <= '0; view_data_q <= '0; saved_q <= 1'b0;
         st_q <= SIDLE; scan_k_q <= '0; min_acc_q <= '0; max_acc_q <= '0;
         sum_q <= '0; dvd_q <= '0; rem_q <= '0; div_cnt_q <= '0;
         min_val_q <= '0; max_val_q <= '0; avg_val_q <= '0; busy_q <= 1'b0;
      end else begin
         trk_q <= trk_d; cand_q <= cand_d; run_q <= run_d;
         wr_ptr_q <= wr_ptr_d; count_q <= count_d; view_idx_q <= view_idx_d;
         view_data_q <= view_data_d; saved_q <= saved_d;
         st_q <= st_d; scan_k_q <= scan_k_d; min_acc_q <= min_acc_d; max_acc_q <= max_acc_d;
         sum_q <= sum_d; dvd_q <= dvd_d; rem_q <= rem_d; div_cnt_q <= div_cnt_d;
         min_val_q <= min_val_d; max_val_q <= max_val_d; avg_val_q <= avg_val_d; busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= cand_d;
   end

   assign bus.saved      = saved_q;
   assign bus.count      = count_q;
   assign bus.view_idx   = view_idx_q;
   assign bus.view_data  = view_data_q;
   assign bus.view_valid = (count_q != '0);
   assign bus.min_val    = min_val_q;
   assign bus.max_val    = max_val_q;
   assign bus.avg_val    = avg_val_q;
   assign bus.stats_busy = busy_q;
endmodule
